// File: rtl/add_arb_pkg.sv
// -----------------------------------------------------------------------------
// add_arb_pkg
// Shared types and widths for the add_arbiter block and its ADD43 adder.
//   A_W   : width of operand A (4)
//   B_W   : width of operand B (3)
//   SUM_W : width of the registered sum (5); 15 + 7 = 22 always fits
//   state_t : result-register occupancy (EMPTY / FULL)
// -----------------------------------------------------------------------------
package add_arb_pkg;

  localparam int A_W   = 4;
  localparam int B_W   = 3;
  localparam int SUM_W = 5;

  typedef logic [A_W-1:0]   a_t;
  typedef logic [B_W-1:0]   b_t;
  typedef logic [SUM_W-1:0] sum_t;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Zero-extends both operands to the sum width before adding, so the
  // carry out of the 4-bit operand lands in the top sum bit.
  function automatic sum_t add_zext(input a_t a, input b_t b);
    sum_t a_ext;
    sum_t b_ext;
    a_ext = {1'b0, a};
    b_ext = {2'b00, b};
    return a_ext + b_ext;
  endfunction

endpackage

// File: rtl/add_arbiter_add43.sv
// -----------------------------------------------------------------------------
// add_arbiter_add43
// The single ADD43 datapath shared by all requesters: a purely
// combinational 4-bit + 3-bit adder with a 5-bit result.
// Ports:
//   a_i   in  A_W   operand A
//   b_i   in  B_W   operand B
//   sum_o out SUM_W zero-extended a_i + b_i
// -----------------------------------------------------------------------------
module add_arbiter_add43
  import add_arb_pkg::*;
(
  input  logic [A_W-1:0]   a_i,
  input  logic [B_W-1:0]   b_i,
  output logic [SUM_W-1:0] sum_o
);

  assign sum_o = add_zext(a_i, b_i);

endmodule

// File: rtl/add_arbiter.sv
// -----------------------------------------------------------------------------
// add_arbiter
// Arbitrates NREQ requesters onto one shared ADD43 adder. One requester is
// granted per cycle; its sum is captured in a one-entry result register
// together with the requester index and presented with a valid/ready
// handshake. Completed result handshakes are counted in an 8-bit
// wrapping counter.
//
// Configuration macro:
//   ADD_ARB_RR_EN  defined   -> round-robin grant starting at a pointer
//                  undefined -> fixed priority, lowest index wins, and the
//                               round-robin pointer register is not built
//
// Parameters:
//   NREQ  number of requesters (2..8)
//   ID_W  requester index width, derived as $clog2(NREQ)
//
// Ports:
//   CLK        in   1        clock, rising edge
//   RST        in   1        synchronous active-high reset
//   REQ_VALID  in   NREQ     per-requester operand valid
//   REQ_A      in   NREQ*4   packed A operands, slice i = [4i+3:4i]
//   REQ_B      in   NREQ*3   packed B operands, slice i = [3i+2:3i]
//   REQ_READY  out  NREQ     one-hot combinational grant
//   RES_VALID  out  1        result register holds a valid sum
//   RES_SUM    out  5        registered sum
//   RES_ID     out  ID_W     index of the requester that produced RES_SUM
//   RES_READY  in   1        consumer takes the result this cycle
//   DONE_CNT   out  8        wrapping count of result handshakes
// -----------------------------------------------------------------------------
module add_arbiter
  import add_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
)(
  input  logic                CLK,
  input  logic                RST,
  input  logic [NREQ-1:0]     REQ_VALID,
  input  logic [NREQ*A_W-1:0] REQ_A,
  input  logic [NREQ*B_W-1:0] REQ_B,
  output logic [NREQ-1:0]     REQ_READY,
  output logic                RES_VALID,
  output logic [SUM_W-1:0]    RES_SUM,
  output logic [ID_W-1:0]     RES_ID,
  input  logic                RES_READY,
  output logic [7:0]          DONE_CNT
);

  // Result register and counter state
  state_t            state_q, state_d;
  sum_t              res_sum_q, res_sum_d;
  logic [ID_W-1:0]   res_id_q, res_id_d;
  logic [7:0]        done_cnt_q, done_cnt_d;

  // Arbitration and datapath nets
  logic              can_accept_s;
  logic              gnt_any_s;
  logic              gnt_fire_s;
  logic              res_hs_s;
  logic [ID_W-1:0]   gnt_idx_s;
  logic [NREQ-1:0]   req_ready_s;
  a_t                a_sel_s;
  b_t                b_sel_s;
  sum_t              sum_s;

`ifdef ADD_ARB_RR_EN
  logic [ID_W-1:0]   ptr_q, ptr_d;
`endif

  // A new operand pair can be taken when the result slot is free or is
  // being emptied this very cycle. Reset suppresses every grant.
  assign can_accept_s = (state_q == EMPTY) || RES_READY;
  assign gnt_fire_s   = gnt_any_s && can_accept_s && !RST;
  assign res_hs_s     = (state_q == FULL) && RES_READY;

`ifdef ADD_ARB_RR_EN
  // Round-robin winner: first valid index at or above the pointer, and if
  // none, first valid index below it. This is the circular search from the
  // pointer, written without a variable bit-select.
  always_comb begin
    gnt_any_s = 1'b0;
    gnt_idx_s = {ID_W{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_any_s && REQ_VALID[i] && (ID_W'(i) >= ptr_q)) begin
        gnt_any_s = 1'b1;
        gnt_idx_s = ID_W'(i);
      end else begin
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_any_s && REQ_VALID[i] && (ID_W'(i) < ptr_q)) begin
        gnt_any_s = 1'b1;
        gnt_idx_s = ID_W'(i);
      end else begin
      end
    end
  end
`else
  // Fixed-priority winner: lowest set index of REQ_VALID.
  always_comb begin
    gnt_any_s = 1'b0;
    gnt_idx_s = {ID_W{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_any_s && REQ_VALID[i]) begin
        gnt_any_s = 1'b1;
        gnt_idx_s = ID_W'(i);
      end else begin
      end
    end
  end
`endif

  // One-hot grant decode and operand mux on the winning index.
  always_comb begin
    req_ready_s = {NREQ{1'b0}};
    a_sel_s     = {A_W{1'b0}};
    b_sel_s     = {B_W{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (ID_W'(i) == gnt_idx_s) begin
        req_ready_s[i] = gnt_fire_s;
        a_sel_s        = REQ_A[i*A_W +: A_W];
        b_sel_s        = REQ_B[i*B_W +: B_W];
      end else begin
        req_ready_s[i] = 1'b0;
      end
    end
  end

  assign REQ_READY = req_ready_s;

  add_arbiter_add43 u_add43 (
    .a_i   (a_sel_s),
    .b_i   (b_sel_s),
    .sum_o (sum_s)
  );

  // Next-state logic for the result slot, its payload and the counter.
  always_comb begin
    state_d    = state_q;
    res_sum_d  = res_sum_q;
    res_id_d   = res_id_q;
    done_cnt_d = done_cnt_q;
    case (state_q)
      EMPTY: begin
        if (gnt_fire_s) begin
          state_d   = FULL;
          res_sum_d = sum_s;
          res_id_d  = gnt_idx_s;
        end else begin
          state_d   = EMPTY;
        end
      end
      FULL: begin
        // A grant while FULL implies RES_READY, so the old result leaves
        // and the new one loads in the same edge.
        if (gnt_fire_s) begin
          state_d   = FULL;
          res_sum_d = sum_s;
          res_id_d  = gnt_idx_s;
        end else if (RES_READY) begin
          state_d   = EMPTY;
        end else begin
          state_d   = FULL;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    if (res_hs_s) begin
      done_cnt_d = done_cnt_q + 8'd1;
    end else begin
      done_cnt_d = done_cnt_q;
    end
  end

`ifdef ADD_ARB_RR_EN
  // Pointer moves to the index just past the last winner, wrapping at NREQ.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_fire_s) begin
      if (gnt_idx_s == ID_W'(NREQ - 1)) begin
        ptr_d = {ID_W{1'b0}};
      end else begin
        ptr_d = gnt_idx_s + ID_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q <= {ID_W{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Result slot, payload and handshake counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= EMPTY;
      res_sum_q  <= {SUM_W{1'b0}};
      res_id_q   <= {ID_W{1'b0}};
      done_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      res_sum_q  <= res_sum_d;
      res_id_q   <= res_id_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign RES_VALID = (state_q == FULL);
  assign RES_SUM   = res_sum_q;
  assign RES_ID    = res_id_q;
  assign DONE_CNT  = done_cnt_q;

endmodule
